abr_arbiter: RTL

Round-robin arbiter for the DUT side of the `abr_if` arbitration interface: the test side drives `request`, and this block returns a one-hot registered `grant`. A grant is held for as long as its owner keeps requesting. When other requesters are waiting, a grant is forcibly revoked after `MAX_HOLD` cycles. The block sits behind the `abr_if` modport opposite `TEST` and serves as the reference arbiter that bench stimulus is checked against.

---
 rtl/abr_pkg.sv | 16 +
 rtl/abr_rr_pick.sv | 34 +++
 rtl/abr_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/abr_pkg.sv
// rtl/abr_pkg.sv - shared state type and one-hot helper for the round-robin arbiter
package abr_pkg;

  localparam int ABR_MAX_N = 32;

  typedef enum logic {
    ABR_IDLE = 1'b0,
    ABR_BUSY = 1'b1
  } abr_state_t;

  // Callers size-cast the result down to their own requester count.
  function automatic logic [ABR_MAX_N-1:0] abr_onehot(input logic [31:0] idx);
    return ABR_MAX_N'(1) << idx;
  endfunction

endpackage

// File: rtl/abr_rr_pick.sv
// rtl/abr_rr_pick.sv - combinational round-robin pick: first set request bit at or above ptr, wrapping
import abr_pkg::*;

module abr_rr_pick #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  request,
  input  logic [PW-1:0] ptr,
  output logic          valid,
  output logic [PW-1:0] idx
);

  logic [N-1:0] rot;

  // Rotate so that bit 0 of rot is request[ptr]; the lowest set bit then wins.
  assign rot = N'({request, request} >> ptr);

  always_comb begin
    int pos;
    valid = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        pos = int'(ptr) + i;
        if (pos >= N) pos = pos - N;
        valid = 1'b1;
        idx   = PW'(pos);
      end
    end
  end

endmodule

// File: rtl/abr_arbiter.sv
// rtl/abr_arbiter.sv - round-robin arbiter with registered one-hot grant and hold-time preemption
import abr_pkg::*;

module abr_arbiter #(
  parameter int N        = 2,
  parameter int MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] request,
  output logic [N-1:0] grant,
  output logic         busy,
  output logic         preempt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

  abr_state_t    state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic          preempt_q, preempt_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [CW-1:0] hold_q, hold_d;

  logic          pick_valid;
  logic [PW-1:0] pick_idx;
  logic [N-1:0]  own_mask;
  logic [PW-1:0] ptr_after_owner;
  logic          timeout;

  abr_rr_pick #(.N(N), .PW(PW)) u_pick (
    .request (request),
    .ptr     (ptr_q),
    .valid   (pick_valid),
    .idx     (pick_idx)
  );

  assign own_mask        = N'(abr_onehot(32'(owner_q)));
  assign ptr_after_owner = (owner_q == PW'(N - 1)) ? '0 : owner_q + PW'(1);
  // Preemption only fires when someone else is actually waiting.
  assign timeout = (MAX_HOLD != 0) && (hold_q == HOLD_MAX) && ((request & ~own_mask) != '0);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    preempt_d = 1'b0;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    hold_d    = hold_q;
    case (state_q)
      ABR_IDLE: begin
        if (pick_valid) begin
          state_d = ABR_BUSY;
          owner_d = pick_idx;
          grant_d = N'(abr_onehot(32'(pick_idx)));
          hold_d  = CW'(1);
        end
      end
      ABR_BUSY: begin
        // Release has priority over timeout, so a simultaneous drop never pulses preempt.
        if (!request[owner_q]) begin
          state_d = ABR_IDLE;
          grant_d = '0;
          ptr_d   = ptr_after_owner;
          hold_d  = '0;
        end else if (timeout) begin
          state_d   = ABR_IDLE;
          grant_d   = '0;
          preempt_d = 1'b1;
          ptr_d     = ptr_after_owner;
          hold_d    = '0;
        end else if (hold_q < HOLD_MAX) begin
          hold_d = hold_q + CW'(1);
        end
      end
      default: begin
        state_d = ABR_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ABR_IDLE;
      grant_q   <= '0;
      preempt_q <= 1'b0;
      ptr_q     <= '0;
      owner_q   <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      preempt_q <= preempt_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      hold_q    <= hold_d;
    end
  end

  assign grant   = grant_q;
  assign preempt = preempt_q;
  assign busy    = (state_q == ABR_BUSY);

endmodule
